// File: rtl/snn_soc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : snn_soc_pkg
// Brief   : Shared FIFO sizing for the SNN SoC (input/output FIFO depths and
//           the occupancy-count width used by the FIFO status window).
// Rev     : 1.0  initial release
// ============================================================================
package snn_soc_pkg;

    localparam int INPUT_FIFO_DEPTH  = 16;
    localparam int OUTPUT_FIFO_DEPTH = 16;

    // Count must hold the value DEPTH itself, hence DEPTH+1 states.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/snn_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module  : snn_fifo_mem
// Brief   : DEPTH x WIDTH register array, one write port, async read port.
// Rev     : 1.0  initial release
// ============================================================================
module snn_fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Combinational read keeps the head word visible without a pop (FWFT).
    assign rd_data = mem_q[rd_addr];

endmodule
`default_nettype wire

// File: rtl/snn_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : snn_sync_fifo
// Brief   : Single-clock FWFT FIFO with registered count/flags, sticky
//           overflow/underflow, peak occupancy and synchronous flush.
// Rev     : 1.0  initial release
// ============================================================================
module snn_sync_fifo
    import snn_soc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] peak_count,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_flags
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] c_ptr_last = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] peak_q, peak_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_en, rd_en, mem_we;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == c_ptr_last) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_en    = push & (~full_q | pop);
        rd_en    = pop & ~empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_we   = wr_en & ~flush;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == c_cnt_full);

        // A new error in the same cycle as clr_flags must survive the clear.
        overflow_d  = (overflow_q & ~clr_flags)  | (push & ~wr_en & ~flush);
        underflow_d = (underflow_q & ~clr_flags) | (pop & empty_q & ~flush);

        if (clr_flags || count_d > peak_q) peak_d = count_d;
        else                               peak_d = peak_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            peak_q      <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            peak_q      <= peak_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    snn_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_data),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

    assign count      = count_q;
    assign empty      = empty_q;
    assign full       = full_q;
    assign peak_count = peak_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_snn_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_snn_sync_fifo
// Brief   : Self-checking bench for snn_sync_fifo (DEPTH=16 and DEPTH=5).
// Rev     : 1.0  initial release
// ============================================================================
module tb_snn_sync_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    // DEPTH=16 instance
    logic        a_flush = 0, a_push = 0, a_pop = 0, a_clr = 0;
    logic [31:0] a_wr_data = '0, a_rd_data;
    logic [4:0]  a_count, a_peak;
    logic        a_empty, a_full, a_ovf, a_unf;

    // DEPTH=5 instance
    logic        b_flush = 0, b_push = 0, b_pop = 0, b_clr = 0;
    logic [31:0] b_wr_data = '0, b_rd_data;
    logic [2:0]  b_count, b_peak;
    logic        b_empty, b_full, b_ovf, b_unf;

    snn_sync_fifo #(.WIDTH(32), .DEPTH(16)) u_dut_a (
        .clk(clk), .rst(rst), .flush(a_flush), .push(a_push), .wr_data(a_wr_data),
        .pop(a_pop), .rd_data(a_rd_data), .count(a_count), .empty(a_empty),
        .full(a_full), .peak_count(a_peak), .overflow(a_ovf), .underflow(a_unf),
        .clr_flags(a_clr)
    );

    snn_sync_fifo #(.WIDTH(32), .DEPTH(5)) u_dut_b (
        .clk(clk), .rst(rst), .flush(b_flush), .push(b_push), .wr_data(b_wr_data),
        .pop(b_pop), .rd_data(b_rd_data), .count(b_count), .empty(b_empty),
        .full(b_full), .peak_count(b_peak), .overflow(b_ovf), .underflow(b_unf),
        .clr_flags(b_clr)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] sb_a [$];
    logic [31:0] sb_b [$];
    int          m_peak = 0;
    logic        m_ovf  = 0;
    logic        m_unf  = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a_state();
        check_eq("a_count", 32'(a_count), 32'(sb_a.size()));
        check_eq("a_empty", 32'(a_empty), 32'(sb_a.size() == 0));
        check_eq("a_full",  32'(a_full),  32'(sb_a.size() == 16));
        check_eq("a_peak",  32'(a_peak),  32'(m_peak));
        check_eq("a_ovf",   32'(a_ovf),   32'(m_ovf));
        check_eq("a_unf",   32'(a_unf),   32'(m_unf));
        if (sb_a.size() > 0) check_eq("a_head", a_rd_data, sb_a[0]);
    endtask

    // One cycle on the DEPTH=16 FIFO with the scoreboard model updated alongside.
    task automatic step_a(input logic p, input logic [31:0] d, input logic po,
                          input logic fl, input logic cl);
        int  sz;
        logic wr, rd;
        sz = sb_a.size();
        wr = p && (sz < 16 || po);
        rd = po && sz > 0;
        if (cl) begin
            m_ovf = 0;
            m_unf = 0;
        end
        if (fl) begin
            sb_a.delete();
        end else begin
            if (rd) begin
                check_eq("a_pop_data", a_rd_data, sb_a.pop_front());
            end
            if (wr) sb_a.push_back(d);
            if (p && !wr) m_ovf = 1;
            if (po && sz == 0) m_unf = 1;
        end
        if (cl || sb_a.size() > m_peak) m_peak = sb_a.size();
        a_push = p; a_wr_data = d; a_pop = po; a_flush = fl; a_clr = cl;
        tick();
        a_push = 0; a_pop = 0; a_flush = 0; a_clr = 0;
        check_a_state();
    endtask

    task automatic step_b(input logic p, input logic [31:0] d, input logic po);
        if (po && sb_b.size() > 0) check_eq("b_pop_data", b_rd_data, sb_b.pop_front());
        if (p && sb_b.size() < 5) sb_b.push_back(d);
        b_push = p; b_wr_data = d; b_pop = po;
        tick();
        b_push = 0; b_pop = 0;
        check_eq("b_count", 32'(b_count), 32'(sb_b.size()));
        if (b_count > 3'd5) check_eq("b_count_bound", 32'(b_count), 32'd5);
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        sb_a.delete();
        sb_b.delete();
        m_peak = 0; m_ovf = 0; m_unf = 0;
        check_a_state();
        check_eq("rst_b_count", 32'(b_count), 32'd0);
        check_eq("rst_b_empty", 32'(b_empty), 32'd1);
        rst = 0;
    endtask

    initial begin
        tick();
        do_reset();

        // Fill to full, then push+pop while full, then a rejected push.
        for (int i = 0; i < 16; i++) step_a(1, 32'h100 + i, 0, 0, 0);
        check_eq("fill_full", 32'(a_full), 32'd1);
        check_eq("fill_peak", 32'(a_peak), 32'd16);
        step_a(1, 32'h55, 1, 0, 0);
        check_eq("fullpp_ovf", 32'(a_ovf), 32'd0);
        step_a(1, 32'hDEAD, 0, 0, 0);
        check_eq("ovf_set", 32'(a_ovf), 32'd1);
        check_eq("ovf_count", 32'(a_count), 32'd16);
        for (int i = 0; i < 16; i++) step_a(0, 0, 1, 0, 0);
        check_eq("drain_empty", 32'(a_empty), 32'd1);

        // Clear flags, then underflow with a simultaneous push.
        step_a(0, 0, 0, 0, 1);
        step_a(1, 32'hA5, 1, 0, 0);
        check_eq("unf_set", 32'(a_unf), 32'd1);
        check_eq("unf_data", a_rd_data, 32'hA5);
        step_a(0, 0, 1, 0, 0);

        // Overflow coinciding with clr_flags, then flush at count=7.
        for (int i = 0; i < 16; i++) step_a(1, 32'h200 + i, 0, 0, 0);
        step_a(1, 32'hBEEF, 0, 0, 1);
        check_eq("clr_vs_ovf", 32'(a_ovf), 32'd1);
        for (int i = 0; i < 9; i++) step_a(0, 0, 1, 0, 0);
        check_eq("pre_flush", 32'(a_count), 32'd7);
        step_a(1, 32'h77, 1, 1, 0);
        check_eq("flush_count", 32'(a_count), 32'd0);
        check_eq("flush_peak", 32'(a_peak), 32'd16);
        check_eq("flush_ovf", 32'(a_ovf), 32'd1);

        // Randomised traffic with occasional flush/clear.
        for (int i = 0; i < 300; i++) begin
            step_a(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 31) == 0), ($urandom_range(0, 15) == 0));
        end

        // Reset mid-stream.
        for (int i = 0; i < 5; i++) step_a(1, 32'h300 + i, 0, 0, 0);
        do_reset();

        // DEPTH=5 wrap: hold occupancy at 3 across many pointer wraps.
        for (int i = 0; i < 3; i++) step_b(1, 32'h500 + i, 0);
        for (int i = 0; i < 23; i++) step_b(1, 32'h600 + i, 1);
        for (int i = 0; i < 3; i++) step_b(0, 0, 1);
        check_eq("b_empty", 32'(b_empty), 32'd1);
        check_eq("b_full", 32'(b_full), 32'd0);
        check_eq("b_peak", 32'(b_peak), 32'd3);
        check_eq("b_ovf", 32'(b_ovf), 32'd0);
        check_eq("b_unf", 32'(b_unf), 32'd0);
        check_eq("b_flush_clr_idle", 32'(b_flush | b_clr), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
